// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM.
// Decodes the instruction opcode and steps the datapath through one
// instruction phase per clock. Moore machine: every control output depends
// only on the current state and is forced to zero while reset is high.
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  // State and latched-opcode registers; reset returns to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; the opcode is captured only on the DECODE edge so
  // later changes on the input cannot redirect MEMADR.
  always_comb begin
    // NOTE: defaults assigned before the case keep every path driven, so no
    // latch is inferred for states or opcodes not listed.
    state_d = S_FETCH;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else                                    state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore output decode, gated by reset so outputs drop the moment it rises.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    pc_source     = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          aluop     = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          aluop         = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed testbench for mc_main_control: walks each instruction class
// through its state sequence and compares state plus all control outputs
// against hand-derived per-state values.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  // Control word packing (msb..lsb): pc_write, pc_write_cond, i_or_d,
  // mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
  // alu_src_a, alu_src_b[1:0], aluop[1:0], pc_source[1:0].
  localparam logic [15:0] C_FETCH  = 16'h9410;
  localparam logic [15:0] C_DECODE = 16'h0030;
  localparam logic [15:0] C_MEMADR = 16'h0060;
  localparam logic [15:0] C_MEMRD  = 16'h3000;
  localparam logic [15:0] C_MEMWB  = 16'h0280;
  localparam logic [15:0] C_MEMWR  = 16'h2800;
  localparam logic [15:0] C_EXEC   = 16'h0048;
  localparam logic [15:0] C_ALUWB  = 16'h0180;
  localparam logic [15:0] C_BRANCH = 16'h4045;
  localparam logic [15:0] C_JUMP   = 16'h8002;
  localparam logic [15:0] C_ADDIEX = 16'h0060;
  localparam logic [15:0] C_ADDIWB = 16'h0080;

  logic [15:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
                 pc_source};

  mc_main_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .aluop         (aluop),
    .pc_source     (pc_source),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare state and full control word, plus the memory/write invariants.
  task automatic expect_state(input string tag, input logic [3:0] st, input logic [15:0] c);
    check({tag, ".state"}, {28'd0, state}, {28'd0, st});
    check({tag, ".ctrl"}, {16'd0, ctrl}, {16'd0, c});
    check({tag, ".rd_wr_excl"}, {31'd0, mem_read & mem_write}, 32'd0);
    check({tag, ".wb_wr_excl"}, {31'd0, reg_write & mem_write}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    expect_state("in_reset", 4'd0, 16'h0000);

    // Release between edges: FETCH outputs visible before the first edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_state("post_reset", 4'd0, C_FETCH);

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    step(); expect_state("lw.decode", 4'd1, C_DECODE);
    step(); expect_state("lw.memadr", 4'd2, C_MEMADR);
    step(); expect_state("lw.memrd",  4'd3, C_MEMRD);
    step(); expect_state("lw.memwb",  4'd4, C_MEMWB);
    step(); expect_state("lw.fetch",  4'd0, C_FETCH);

    // sw, opcode flipped to lw during MEMADR: 0,1,2,5,0
    opcode = 6'b101011;
    step(); expect_state("sw.decode", 4'd1, C_DECODE);
    step(); expect_state("sw.memadr", 4'd2, C_MEMADR);
    opcode = 6'b100011;
    step(); expect_state("sw.memwr",  4'd5, C_MEMWR);
    step(); expect_state("sw.fetch",  4'd0, C_FETCH);

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    step(); expect_state("r.decode", 4'd1, C_DECODE);
    step(); expect_state("r.exec",   4'd6, C_EXEC);
    step(); expect_state("r.aluwb",  4'd7, C_ALUWB);
    step(); expect_state("r.fetch",  4'd0, C_FETCH);

    // beq: 0,1,8,0
    opcode = 6'b000100;
    step(); expect_state("beq.decode", 4'd1, C_DECODE);
    step(); expect_state("beq.branch", 4'd8, C_BRANCH);
    step(); expect_state("beq.fetch",  4'd0, C_FETCH);

    // j: 0,1,9,0
    opcode = 6'b000010;
    step(); expect_state("j.decode", 4'd1, C_DECODE);
    step(); expect_state("j.jump",   4'd9, C_JUMP);
    step(); expect_state("j.fetch",  4'd0, C_FETCH);

    // illegal: 0,1,0
    opcode = 6'b111111;
    step(); expect_state("ill.decode", 4'd1, C_DECODE);
    step(); expect_state("ill.fetch",  4'd0, C_FETCH);

    // addi: 0,1,10,11,0
    opcode = 6'b001000;
    step(); expect_state("addi.decode", 4'd1,  C_DECODE);
    step(); expect_state("addi.ex",     4'd10, C_ADDIEX);
    step(); expect_state("addi.wb",     4'd11, C_ADDIWB);
    step(); expect_state("addi.fetch",  4'd0,  C_FETCH);

    // lw aborted by reset in MEMRD.
    opcode = 6'b100011;
    step(); expect_state("abort.decode", 4'd1, C_DECODE);
    step(); expect_state("abort.memadr", 4'd2, C_MEMADR);
    step(); expect_state("abort.memrd",  4'd3, C_MEMRD);
    #2;
    reset = 1'b1;
    #1;
    expect_state("abort.in_reset", 4'd0, 16'h0000);
    opcode = 6'b111111;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_state("abort.release", 4'd0, C_FETCH);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("abort.no_wb%0d", i), {31'd0, reg_write}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

  // Hard bound on run time in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
